// File: rtl/general_register_file.sv
// Operand register file feeding the ALU: four general (R1..R4) and four
// temporary (T1..T4) registers with shared load/clear/inc/dec control.
module general_register_file #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] I,
   input  logic [1:0]       FunSel,
   input  logic [3:0]       RSel,
   input  logic [3:0]       TSel,
   input  logic [2:0]       OutASel,
   input  logic [2:0]       OutBSel,
   output logic [WIDTH-1:0] OutA,
   output logic [WIDTH-1:0] OutB
);

   typedef enum logic [1:0] {
      FS_DEC   = 2'b00,
      FS_INC   = 2'b01,
      FS_LOAD  = 2'b10,
      FS_CLEAR = 2'b11
   } fun_sel_e;

   // Index 0..3 = R1..R4, 4..7 = T1..T4, matching the read select encoding.
   logic [WIDTH-1:0] regs [8];
   logic [7:0]       en;

   assign en = {TSel, RSel};

   function automatic logic [WIDTH-1:0] next_val(
      input logic [1:0]       fs,
      input logic [WIDTH-1:0] cur,
      input logic [WIDTH-1:0] din
   );
      logic [WIDTH-1:0] res;
      unique case (fs)
         FS_DEC:   res = cur - WIDTH'(1);
         FS_INC:   res = cur + WIDTH'(1);
         FS_LOAD:  res = din;
         FS_CLEAR: res = '0;
         default:  res = cur;
      endcase
      return res;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 8; k++) regs[k] <= '0;
      end else begin
         for (int k = 0; k < 8; k++) begin
            if (en[k]) regs[k] <= next_val(FunSel, regs[k], I);
         end
      end
   end

   function automatic logic [WIDTH-1:0] rd_mux(input logic [2:0] sel);
      logic [WIDTH-1:0] res;
      unique case (sel)
         3'd0:    res = regs[0];
         3'd1:    res = regs[1];
         3'd2:    res = regs[2];
         3'd3:    res = regs[3];
         3'd4:    res = regs[4];
         3'd5:    res = regs[5];
         3'd6:    res = regs[6];
         3'd7:    res = regs[7];
         default: res = '0;
      endcase
      return res;
   endfunction

   always_comb begin
      OutA = rd_mux(OutASel);
      OutB = rd_mux(OutBSel);
   end

endmodule

// File: tb/tb_general_register_file.sv
// Scoreboard bench for general_register_file: stimulus queues expected
// OutA/OutB pairs, a negedge monitor pops and compares them.
module tb_general_register_file;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] I;
   logic [1:0] FunSel;
   logic [3:0] RSel;
   logic [3:0] TSel;
   logic [2:0] OutASel;
   logic [2:0] OutBSel;
   logic [7:0] OutA;
   logic [7:0] OutB;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] ea;
      logic [7:0] eb;
      string      nm;
   } exp_t;

   exp_t exp_q[$];

   general_register_file #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .I(I), .FunSel(FunSel),
      .RSel(RSel), .TSel(TSel), .OutASel(OutASel), .OutBSel(OutBSel),
      .OutA(OutA), .OutB(OutB)
   );

   always #5 clk = ~clk;

   // Reference ALU add used for the operand chain check.
   logic [7:0] alu_out;
   logic       alu_v;
   logic       alu_n;
   assign alu_out = OutA + OutB;
   assign alu_v   = (OutA[7] == OutB[7]) && (alu_out[7] != OutA[7]);
   assign alu_n   = alu_out[7];

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if (OutA !== e.ea || OutB !== e.eb) begin
            failures++;
            $display("FAIL %s: OutA=%02h OutB=%02h expected OutA=%02h OutB=%02h",
                     e.nm, OutA, OutB, e.ea, e.eb);
         end
      end
   end

   // One call = one clock cycle. Inputs apply on the next edge; a queued
   // check samples outputs before that edge.
   task automatic cyc(input logic rst, input logic [1:0] fs,
                      input logic [3:0] rs, input logic [3:0] ts,
                      input logic [7:0] din, input logic [2:0] asel,
                      input logic [2:0] bsel, input logic chk,
                      input logic [7:0] ea, input logic [7:0] eb,
                      input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = rst; FunSel = fs; RSel = rs; TSel = ts; I = din;
      OutASel = asel; OutBSel = bsel;
      if (chk) begin
         e.ea = ea; e.eb = eb; e.nm = nm;
         exp_q.push_back(e);
      end
   endtask

   task automatic nop_chk(input logic [2:0] asel, input logic [2:0] bsel,
                          input logic [7:0] ea, input logic [7:0] eb,
                          input string nm);
      cyc(1, 2'b00, 4'h0, 4'h0, 8'h00, asel, bsel, 1, ea, eb, nm);
   endtask

   task automatic wr(input logic [1:0] fs, input logic [3:0] rs,
                     input logic [3:0] ts, input logic [7:0] din);
      cyc(1, fs, rs, ts, din, 3'd0, 3'd0, 0, 8'h00, 8'h00, "");
   endtask

   task automatic direct(input logic ok, input string nm,
                         input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got %02h expected %02h", nm, act, req);
      end
   endtask

   initial begin
      rst_n = 1'b0; I = '0; FunSel = '0; RSel = '0; TSel = '0;
      OutASel = '0; OutBSel = '0;
      cyc(0, 2'b00, 4'h0, 4'h0, 8'h00, 3'd0, 3'd0, 0, 8'h00, 8'h00, "");
      nop_chk(3'd0, 3'd7, 8'h00, 8'h00, "post_reset");

      // reset overrides a concurrent all-register load
      wr(2'b10, 4'hF, 4'hF, 8'hAA);
      cyc(0, 2'b10, 4'hF, 4'hF, 8'h55, 3'd0, 3'd7, 1, 8'hAA, 8'hAA, "pre_reset_aa");
      for (int k = 0; k < 8; k++)
         nop_chk(3'(k), 3'(7 - k), 8'h00, 8'h00, "reset_all");

      wr(2'b10, 4'b0010, 4'b0000, 8'h3C);
      wr(2'b10, 4'b0000, 4'b1000, 8'hC3);
      nop_chk(3'd1, 3'd7, 8'h3C, 8'hC3, "load_r2_t4");
      nop_chk(3'd0, 3'd2, 8'h00, 8'h00, "load_others_a");
      nop_chk(3'd3, 3'd4, 8'h00, 8'h00, "load_others_b");
      nop_chk(3'd5, 3'd6, 8'h00, 8'h00, "load_others_c");

      wr(2'b11, 4'b0001, 4'b0000, 8'h77);
      wr(2'b00, 4'b0001, 4'b0000, 8'h00);
      cyc(1, 2'b01, 4'b0001, 4'b0000, 8'h00, 3'd0, 3'd0, 1, 8'hFF, 8'hFF, "dec_wrap");
      cyc(1, 2'b01, 4'b0001, 4'b0000, 8'h00, 3'd0, 3'd1, 1, 8'h00, 8'h3C, "inc_wrap");
      nop_chk(3'd0, 3'd0, 8'h01, 8'h01, "inc_again");

      wr(2'b10, 4'b0001, 4'b0000, 8'h05);
      wr(2'b10, 4'b0100, 4'b0000, 8'hFF);
      wr(2'b10, 4'b0000, 4'b0010, 8'h80);
      wr(2'b01, 4'b0101, 4'b0010, 8'h00);
      nop_chk(3'd0, 3'd2, 8'h06, 8'h00, "multi_r1_r3");
      nop_chk(3'd5, 3'd1, 8'h81, 8'h3C, "multi_t2_r2");
      nop_chk(3'd3, 3'd7, 8'h00, 8'hC3, "multi_r4_t4");
      nop_chk(3'd4, 3'd6, 8'h00, 8'h00, "multi_t1_t3");

      wr(2'b10, 4'b1000, 4'b0000, 8'h10);
      cyc(1, 2'b10, 4'b1000, 4'b0000, 8'h20, 3'd3, 3'd3, 1, 8'h10, 8'h10, "rdw_before");
      nop_chk(3'd3, 3'd3, 8'h20, 8'h20, "rdw_after");

      wr(2'b10, 4'b0001, 4'b0000, 8'h7F);
      wr(2'b10, 4'b0010, 4'b0000, 8'h01);
      nop_chk(3'd0, 3'd1, 8'h7F, 8'h01, "alu_operands");
      @(negedge clk);
      #1;
      direct(alu_out == 8'h80, "alu_sum", alu_out, 8'h80);
      direct(alu_v == 1'b1, "alu_ovf", {7'd0, alu_v}, 8'h01);
      direct(alu_n == 1'b1, "alu_neg", {7'd0, alu_n}, 8'h01);
      cyc(1, 2'b10, 4'b0000, 4'b0001, 8'h80, 3'd0, 3'd1, 0, 8'h00, 8'h00, "");
      nop_chk(3'd4, 3'd0, 8'h80, 8'h7F, "writeback_t1");

      @(posedge clk);
      @(posedge clk);
      direct(exp_q.size() == 0, "queue_drained", 8'(exp_q.size()), 8'h00);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: sim time exceeded");
      $fatal(1);
   end

endmodule

// File: doc/general_register_file.md
Name: general_register_file

Overview:
- Upstream operand stage of the ALU. Holds 4 general-purpose registers (R1..R4) and 4 temporary registers (T1..T4), each WIDTH bits.
- Per-cycle register operations: load, clear, increment, decrement.
- Two independent read ports, OutA and OutB, drive the ALU A and B operand inputs directly.
- ALU results return through input I on a later cycle (write-back path).

Parameters:
- WIDTH, 8, data width of every register and port; matches the ALU operand width.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- I  input  WIDTH  write data for load operation (ALU OutALU or memory data)
- FunSel  input  2  operation applied to every enabled register: 00 decrement, 01 increment, 10 load I, 11 clear
- RSel  input  4  one-hot-or-more enable for R1..R4; bit0=R1 ... bit3=R4; 1 = enabled
- TSel  input  4  enable for T1..T4; bit0=T1 ... bit3=T4; 1 = enabled
- OutASel  input  3  read select A: 000..011 = R1..R4, 100..111 = T1..T4
- OutBSel  input  3  read select B, same encoding as OutASel
- OutA  output  WIDTH  contents of register selected by OutASel
- OutB  output  WIDTH  contents of register selected by OutBSel

Behaviour:
- Reset: on a rising edge with rst_n=0, all 8 registers become 0. Reset overrides any FunSel/RSel/TSel activity in that cycle. OutA and OutB therefore read 0 from the cycle after reset.
- Reset mid-operation: any register update requested in the reset cycle is discarded. No partial state survives.
- Write: on a rising edge with rst_n=1, every register whose enable bit is 1 takes the FunSel result computed from its own current value:
  - 00 decrement: value - 1, modulo 2^WIDTH (0x00 -> 0xFF).
  - 01 increment: value + 1, modulo 2^WIDTH (0xFF -> 0x00).
  - 10 load: I.
  - 11 clear: 0.
- Registers whose enable bit is 0 hold their value.
- Multiple enables: any number of the 8 enable bits may be set at once. Each enabled register applies the same FunSel independently, e.g. inc on R1=0x05 and R2=0xFF gives 0x06 and 0x00. All-zero enables is a no-op cycle.
- Read ports: purely combinational muxes from register state; no read latency.
  - OutA and OutB may select the same register; both then show the same value.
- Read during write: in the cycle a register is written, OutA/OutB show its pre-edge value. The new value appears after the edge. There is no write-through from I to the outputs.
- Latency to ALU: the ALU samples OutA/OutB on the same edge that updates this block. An operand written on edge n is consumed by the ALU on edge n+1; the ALU result is valid after that edge.
- No X on outputs after reset for any select value; all 3-bit select codes are legal.
- Implementation: one always block on posedge clk for state, combinational case muxes for the read ports. No latches, no asynchronous paths.

Test Plan:
- Reset: write 0xAA to all 8 registers, then assert rst_n=0 for one edge while FunSel=10, RSel=1111, TSel=1111, I=0x55 -> every OutASel/OutBSel code reads 0x00.
- Load/readback: load I=0x3C into R2 only (RSel=0010), then I=0xC3 into T4 (TSel=1000); OutASel=001, OutBSel=111 -> OutA=0x3C, OutB=0xC3; all other registers remain 0x00.
- Wrap-around: clear R1, then decrement R1 -> 0xFF; increment R1 twice -> 0x00 then 0x01.
- Multi-enable: R1=0x05, R3=0xFF, T2=0x80; increment with RSel=0101, TSel=0010 -> R1=0x06, R3=0x00, T2=0x81; R2, R4 and other temp registers unchanged.
- Read-during-write: R4=0x10, OutASel=011, load I=0x20 into R4 -> OutA=0x10 before the edge, 0x20 after the edge; OutBSel=011 tracks identically.
- ALU chain: load R1=0x7F, R2=0x01, set OutASel=000, OutBSel=001, ALU FunSel=0100 -> one edge later OutALU=0x80 and ALU overflow and N flags set. Write the result back into T1 via I (TSel=0001, FunSel=10) -> T1 reads 0x80.
